// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional counters are enabled with `define FETCH_PERF_CNT_EN.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  // The same encoding is used by the control decoder.
  localparam logic [4:0] OPC_HALT = 5'b00000;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_ifid_buf.sv
// Single-entry IF/ID holding register.
// Priority is flush, then load, then consume.
module fetch_ifid_buf #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc_plus2,
  input  logic               consume,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus2
);

  logic               valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  pc_plus2_r;

  // Buffer state update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      instr_r    <= {INSTR_W{1'b0}};
      pc_plus2_r <= {ADDR_W{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r    <= 1'b1;
      instr_r    <= load_instr;
      pc_plus2_r <= load_pc_plus2;
    end else if (consume) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid    = valid_r;
  assign instr    = instr_r;
  assign pc_plus2 = pc_plus2_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time.
// Optional counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [4:0]         id_opcode,
  output logic [ADDR_W-1:0]  id_pc_plus2,
  output logic               halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        squash_cnt,
`endif
  output logic               err
);

  fetch_state_e       state_r;
  logic [ADDR_W-1:0]  pc_r;
  logic               squash_r;
  logic               halted_r;
  logic               err_r;

  logic               id_valid_s;
  logic               buf_free_s;
  logic               active_s;
  logic               req_fire_s;
  logic               redir_s;
  logic               halt_take_s;
  logic               rsp_load_s;
  logic               rsp_drop_s;
  logic [ADDR_W-1:0]  pc_plus2_s;

  assign active_s    = (state_r != ST_HALTED);
  assign buf_free_s  = !id_valid_s || id_ready;
  // rst_n gate keeps the request low while reset is asserted.
  assign imem_req_valid = rst_n && (state_r == ST_REQ) && buf_free_s;
  assign req_fire_s  = imem_req_valid && imem_req_ready;
  assign redir_s     = active_s && redirect_valid;
  assign halt_take_s = active_s && id_valid_s && halt && !redirect_valid;
  assign rsp_load_s  = (state_r == ST_WAIT) && imem_rsp_valid && !squash_r && !redirect_valid;
  assign rsp_drop_s  = (state_r == ST_WAIT) && imem_rsp_valid && (squash_r || redirect_valid);
  assign pc_plus2_s  = pc_r + ADDR_W'(2);

  // Fetch control: state, PC, squash and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_REQ;
      pc_r     <= RESET_PC;
      squash_r <= 1'b0;
      halted_r <= 1'b0;
      err_r    <= 1'b0;
    end else if (redir_s && redirect_pc[0]) begin
      err_r    <= 1'b1;
      halted_r <= 1'b1;
      state_r  <= ST_HALTED;
    end else if (redir_s) begin
      pc_r <= redirect_pc;
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            state_r  <= ST_WAIT;
            squash_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_r <= ST_REQ;
          end else begin
            squash_r <= 1'b1;
          end
        end
        default: state_r <= ST_REQ;
      endcase
    end else if (halt_take_s) begin
      halted_r <= 1'b1;
      state_r  <= ST_HALTED;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            state_r  <= ST_WAIT;
            squash_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_r <= ST_REQ;
            if (!squash_r) begin
              pc_r <= pc_plus2_s;
            end
          end
        end
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_REQ;
      endcase
    end
  end

  fetch_ifid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (redir_s || halt_take_s),
    .load          (rsp_load_s),
    .load_instr    (imem_rsp_data),
    .load_pc_plus2 (pc_plus2_s),
    .consume       (id_ready),
    .valid         (id_valid_s),
    .instr         (id_instr),
    .pc_plus2      (id_pc_plus2)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] squash_cnt_r;

  // Saturating counters of loaded and dropped responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r  <= 32'd0;
      squash_cnt_r <= 32'd0;
    end else begin
      if (rsp_load_s) begin
        fetch_cnt_r <= sat_inc(fetch_cnt_r);
      end
      if (rsp_drop_s) begin
        squash_cnt_r <= sat_inc(squash_cnt_r);
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_r;
  assign squash_cnt = squash_cnt_r;
`else
  logic unused_s;
  assign unused_s = rsp_drop_s;
`endif

  assign imem_req_addr = pc_r;
  assign id_valid      = id_valid_s;
  assign id_opcode     = id_instr[INSTR_W-1 -: 5];
  assign halted        = halted_r;
  assign err           = err_r;

endmodule
